midi_tx: RTL and testbench

Serial MIDI transmitter: accepts bytes over a valid/ready handshake, buffers them in a small FIFO and shifts each out as a 31250-baud 8N1 UART frame on a single output pin. It is the outbound counterpart to `midi_rx` in `trivius_top`. It lets the synth echo, thru or generate MIDI (note on/off, clock) towards external gear.

---
 rtl/midi_pkg.sv | 14 +
 rtl/midi_tx_fifo.sv | 32 +++
 rtl/midi_tx.sv | 80 ++++++++
 tb/tb_midi_tx.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/midi_pkg.sv
// midi_pkg: MIDI constants, transmitter state enum and status-byte classifiers shared by midi_tx and midi_rx.
package midi_pkg;
    localparam int MidiBaud = 31250;
    localparam logic [7:0] MidiStatusMin = 8'h80;
    localparam logic [7:0] MidiSysCommon = 8'hF0;
    localparam logic [7:0] MidiRealTime = 8'hF8;
    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} tx_state_e;
    function automatic logic is_channel_status(input logic [7:0] b);
        return b >= MidiStatusMin && b < MidiSysCommon;
    endfunction
    function automatic logic is_realtime(input logic [7:0] b);
        return b >= MidiRealTime;
    endfunction
endpackage

// File: rtl/midi_tx_fifo.sv
// midi_tx_fifo: synchronous Depth x 8 FIFO; pointers carry an extra wrap bit to tell full from empty.
module midi_tx_fifo #(
    parameter int Depth = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(Depth);
    logic [7:0] mem [Depth];
    logic [AW:0] wr_ptr, rd_ptr;
    assign empty = wr_ptr == rd_ptr;
    assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout = mem[rd_ptr[AW-1:0]];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/midi_tx.sv
// midi_tx: FIFO-buffered 8N1 MIDI UART transmitter, one frame per popped byte.
// Optional running-status suppression is enabled by defining MIDI_TX_RUNNING_STATUS_EN.
module midi_tx
    import midi_pkg::*;
#(
    parameter int BitDiv = 1535,
    parameter int Depth = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    output logic       o_ready,
    output logic       o_busy,
    output logic       o_tx
);
    localparam int DW = $clog2(BitDiv + 1);
    tx_state_e state, next_state;
    logic [DW-1:0] div_cnt;
    logic [2:0] bit_cnt;
    logic [7:0] shift, fifo_data;
    logic full, empty, pop, drop, load, bit_end;
    midi_tx_fifo #(.Depth(Depth)) u_fifo (
        .clk(i_clk),
        .rst_n(i_rst_n),
        .push(i_valid && o_ready),
        .din(i_data),
        .pop(pop),
        .dout(fifo_data),
        .full(full),
        .empty(empty)
    );
    assign o_ready = !full;
    assign o_busy = state != ST_IDLE || !empty;
    assign bit_end = div_cnt == DW'(BitDiv);
    assign load = pop && !drop;
`ifdef MIDI_TX_RUNNING_STATUS_EN
    logic [7:0] running;
    assign drop = is_channel_status(fifo_data) && fifo_data == running;
    // Real-time and data bytes leave running status alone; system common cancels it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) running <= 8'h00;
        else if (load) running <= is_channel_status(fifo_data) ? fifo_data :
                                  (is_realtime(fifo_data) || fifo_data < MidiSysCommon) ? running : 8'h00;
    end
`else
    assign drop = 1'b0;
`endif
    always_comb begin
        next_state = state;
        pop = 1'b0;
        case (state)
            ST_IDLE: begin
                pop = !empty;
                next_state = (!empty && !drop) ? ST_START : ST_IDLE;
            end
            ST_START: next_state = bit_end ? ST_DATA : ST_START;
            ST_DATA: next_state = (bit_end && bit_cnt == 3'd7) ? ST_STOP : ST_DATA;
            default: next_state = bit_end ? ST_IDLE : ST_STOP;
        endcase
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= ST_IDLE;
        else state <= next_state;
    end
    // o_tx is a registered copy of the current state's line level, one cycle behind the FSM.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            shift <= '0;
            o_tx <= 1'b1;
        end else begin
            div_cnt <= (state == ST_IDLE || state != next_state || bit_end) ? '0 : div_cnt + 1'b1;
            bit_cnt <= state == ST_START ? 3'd0 : (state == ST_DATA && bit_end) ? bit_cnt + 3'd1 : bit_cnt;
            shift <= load ? fifo_data : (state == ST_DATA && bit_end) ? shift >> 1 : shift;
            o_tx <= state == ST_START ? 1'b0 : state == ST_DATA ? shift[0] : 1'b1;
        end
    end
endmodule

// File: tb/tb_midi_tx.sv
// tb_midi_tx: directed bench for midi_tx at BitDiv=3, Depth=4 with a serial decoder on o_tx.
module tb_midi_tx;
    logic clk, rst_n, i_valid, o_ready, o_busy, o_tx;
    logic [7:0] i_data;
    int n_cmp = 0, n_err = 0, cyc = 0, rst_cnt = 0, ferr = 0;
    logic [7:0] rxq[$];
    logic [7:0] exp_q[$];
    int stq[$];
    logic [7:0] d_byte;
    logic d_frame;
    int d_st, d_rc;
    midi_tx #(.BitDiv(3), .Depth(4)) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_data(i_data),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .o_busy(o_busy),
        .o_tx(o_tx)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge rst_n) rst_cnt = rst_cnt + 1;
    // Decoder: samples each bit mid-period; frames overlapping a reset are discarded.
    always begin
        @(negedge clk);
        if (rst_n === 1'b1 && o_tx === 1'b0) begin
            d_st = cyc;
            d_rc = rst_cnt;
            repeat (2) @(negedge clk);
            d_frame = (o_tx === 1'b0);
            for (int i = 0; i < 8; i++) begin
                repeat (4) @(negedge clk);
                d_byte[i] = o_tx;
            end
            repeat (4) @(negedge clk);
            d_frame = d_frame && (o_tx === 1'b1);
            if (d_rc == rst_cnt && rst_n === 1'b1) begin
                if (d_frame) begin
                    rxq.push_back(d_byte);
                    stq.push_back(d_st);
                end else ferr = ferr + 1;
            end
        end
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask
    task automatic send(input logic [7:0] b, output int edges);
        logic rdy;
        i_data = b;
        i_valid = 1'b1;
        edges = 0;
        do begin
            rdy = o_ready;
            @(posedge clk);
            #1;
            edges++;
        end while (!rdy && edges < 200);
    endtask
    task automatic check_rx(input string tag);
        int t = 0;
        while (rxq.size() < exp_q.size() && t < 3000) begin
            @(posedge clk);
            t++;
        end
        repeat (60) @(posedge clk);
        #1;
        chk({tag, "_count"}, rxq.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < rxq.size(); k++) chk({tag, "_byte"}, rxq[k], exp_q[k]);
        chk({tag, "_busy"}, o_busy, 1'b0);
    endtask
    task automatic clear_rx();
        rxq.delete();
        stq.delete();
    endtask
    initial begin
        logic [9:0] frame;
        int e, tot, lows;
        rst_n = 1'b0;
        i_valid = 1'b0;
        i_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_tx", o_tx, 1'b1);
        chk("rst_ready", o_ready, 1'b1);
        chk("rst_busy", o_busy, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        // Single byte 0x90: stop, data MSB..LSB, start
        frame = {1'b1, 8'h90, 1'b0};
        send(8'h90, e);
        i_valid = 1'b0;
        chk("single_accept_edges", e, 1);
        chk("single_busy_after_push", o_busy, 1'b1);
        chk("single_tx_n0", o_tx, 1'b1);
        @(posedge clk);
        #1;
        chk("single_tx_n1", o_tx, 1'b1);
        @(posedge clk);
        #1;
        for (int c = 0; c < 40; c++) begin
            chk("single_tx_bit", o_tx, frame[c/4]);
            if (c < 39) chk("single_busy", o_busy, 1'b1);
            @(posedge clk);
            #1;
        end
        chk("single_tx_after", o_tx, 1'b1);
        chk("single_busy_after", o_busy, 1'b0);
        exp_q = '{8'h90};
        check_rx("single");
        clear_rx();
        // Backpressure: hold valid for 0x01..0x06
        tot = 0;
        for (int b = 1; b <= 6; b++) begin
            send(8'(b), e);
            tot += e;
            if (b == 5) begin
                chk("bp_5_edge", tot, 5);
                chk("bp_full_ready", o_ready, 1'b0);
            end
        end
        i_valid = 1'b0;
        chk("bp_6_window", (tot >= 42 && tot <= 44), 1'b1);
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        check_rx("bp");
        for (int k = 1; k < stq.size(); k++) chk("bp_gap", stq[k] - stq[k-1], 41);
        clear_rx();
        // Running-status stimulus
        foreach (exp_q[k]) exp_q[k] = 8'h00;
        send(8'h90, e); send(8'h3C, e); send(8'h64, e);
        send(8'h90, e); send(8'h3E, e); send(8'h64, e);
        i_valid = 1'b0;
`ifdef MIDI_TX_RUNNING_STATUS_EN
        exp_q = '{8'h90, 8'h3C, 8'h64, 8'h3E, 8'h64};
`else
        exp_q = '{8'h90, 8'h3C, 8'h64, 8'h90, 8'h3E, 8'h64};
`endif
        check_rx("rs");
        clear_rx();
        // Status classes
        send(8'h90, e); send(8'hF8, e); send(8'h90, e); send(8'hF0, e); send(8'h90, e);
        i_valid = 1'b0;
`ifdef MIDI_TX_RUNNING_STATUS_EN
        exp_q = '{8'h90, 8'hF8, 8'hF0, 8'h90};
`else
        exp_q = '{8'h90, 8'hF8, 8'h90, 8'hF0, 8'h90};
`endif
        check_rx("cls");
        clear_rx();
        // Reset during DATA bit 3 with two bytes queued
        send(8'h55, e); send(8'hA5, e); send(8'h33, e);
        i_valid = 1'b0;
        e = 0;
        while (o_tx !== 1'b0 && e < 20) begin
            @(posedge clk);
            #1;
            e++;
        end
        chk("mid_start_seen", o_tx, 1'b0);
        repeat (17) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tx", o_tx, 1'b1);
        chk("mid_rst_ready", o_ready, 1'b1);
        chk("mid_rst_busy", o_busy, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (o_tx !== 1'b1) lows++;
        end
        chk("mid_quiet_lows", lows, 0);
        chk("mid_quiet_busy", o_busy, 1'b0);
        chk("mid_quiet_rx", rxq.size(), 0);
        clear_rx();
        send(8'h42, e);
        i_valid = 1'b0;
        exp_q = '{8'h42};
        check_rx("post_rst");
        chk("frame_errors", ferr, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
